// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1-style UART receiver with a check slot, delivering bytes
// on a valid/ack handshake with parity, framing and overrun status.
module uart_rx_byte #(
    parameter int CLK_DIV  = 868,
    parameter int PAR_MODE = 0
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       uart_rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       par_err,
    output logic       frm_err,
    output logic       ovr_err,
    output logic       rx_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, CHK, STOP, WAIT_HI} state_t;

    localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] FULL = 16'(CLK_DIV - 1);

    state_t      state, state_nx;
    logic        sync1, line_s;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        chk_bit;
    logic        half_hit, full_hit, restart, good, bad, par;

    assign half_hit = bit_cnt == HALF;
    assign full_hit = bit_cnt == FULL;
    assign restart  = (state == START) ? half_hit : full_hit;
    assign rx_busy  = state != IDLE;
    assign par      = (PAR_MODE == 1) ? (chk_bit != ^shift) :
                      (PAR_MODE == 2) ? (chk_bit != ~^shift) : 1'b0;

    always_comb begin
        state_nx = state;
        good     = 1'b0;
        bad      = 1'b0;
        case (state)
            IDLE:    if (!line_s) state_nx = START;
            START:   if (half_hit) state_nx = line_s ? IDLE : DATA;
            DATA:    if (full_hit && bit_idx == 3'd7) state_nx = CHK;
            CHK:     if (full_hit) state_nx = STOP;
            STOP: begin
                if (full_hit) begin
                    state_nx = line_s ? IDLE : WAIT_HI;
                    good     = line_s;
                    bad      = !line_s;
                end
            end
            // a held-low line (break) must go high before another start is seen
            WAIT_HI: if (line_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            line_s  <= 1'b1;
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            chk_bit <= 1'b0;
            rx_data <= '0;
            rx_vld  <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            sync1   <= uart_rx;
            line_s  <= sync1;
            state   <= state_nx;
            bit_cnt <= (state == IDLE || state == WAIT_HI || restart) ? 16'd0 : bit_cnt + 16'd1;
            if (state == START) bit_idx <= '0;
            if (state == DATA && full_hit) begin
                shift   <= {line_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (state == CHK && full_hit) chk_bit <= line_s;
            frm_err <= bad;
            ovr_err <= good && rx_vld && !rx_ack;
            if (good) begin
                rx_data <= shift;
                par_err <= par;
                rx_vld  <= 1'b1;
            end else if (rx_ack) begin
                rx_vld  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed frames against a frame-level model of the receiver,
// checked every cycle, plus hand-computed spot checks.
module tb_uart_rx_byte;
    localparam int DIV = 16;
    localparam int LAT = 2 + DIV / 2 + 10 * DIV + 1;

    logic       clk_sys = 1'b0, rst_n = 1'b0, uart_rx = 1'b1, rx_ack = 1'b0;
    logic [7:0] rx_data, rx_data0;
    logic       rx_vld, par_err, frm_err, ovr_err, rx_busy;
    logic       rx_vld0, par_err0, frm_err0, ovr_err0, rx_busy0;

    always #5 clk_sys = ~clk_sys;

    uart_rx_byte #(.CLK_DIV(DIV), .PAR_MODE(1)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .uart_rx(uart_rx), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_vld(rx_vld), .par_err(par_err), .frm_err(frm_err),
        .ovr_err(ovr_err), .rx_busy(rx_busy)
    );

    uart_rx_byte #(.CLK_DIV(DIV), .PAR_MODE(0)) dut0 (
        .clk_sys(clk_sys), .rst_n(rst_n), .uart_rx(uart_rx), .rx_ack(rx_ack),
        .rx_data(rx_data0), .rx_vld(rx_vld0), .par_err(par_err0), .frm_err(frm_err0),
        .ovr_err(ovr_err0), .rx_busy(rx_busy0)
    );

    typedef struct {int due; logic [7:0] d; logic c; logic s;} ev_t;
    ev_t q[$];
    ev_t ev;
    int cyc = 0, total = 0, bad = 0, rise_cyc = 0, frm_cnt = 0, ovr_cnt = 0, last_c0 = 0;
    logic [7:0] m_data = '0;
    logic m_vld = 0, m_par = 0, m_frm = 0, m_ovr = 0, prev_vld = 0, ack_s = 0, g = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // even parity: the check slot should equal the xor of the data bits
    function automatic logic even_err(input logic [7:0] d, input logic c);
        return c != ($countones(d) % 2 == 1);
    endfunction

    always @(posedge clk_sys) begin
        cyc++;
        ack_s = rx_ack;
        m_frm = 0;
        m_ovr = 0;
        g     = 0;
        if (!rst_n) begin
            m_vld  = 0;
            m_data = '0;
            m_par  = 0;
            q.delete();
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                ev = q.pop_front();
                if (ev.s) g = 1;
                else m_frm = 1;
            end
            if (g) begin
                m_ovr  = m_vld && !ack_s;
                m_vld  = 1;
                m_data = ev.d;
                m_par  = even_err(ev.d, ev.c);
            end else if (ack_s) begin
                m_vld = 0;
            end
        end
        #1;
        chk("rx_data", rx_data, m_data);
        chk("rx_vld", rx_vld, m_vld);
        chk("frm_err", frm_err, m_frm);
        chk("ovr_err", ovr_err, m_ovr);
        chk("rx_data_m0", rx_data0, m_data);
        chk("rx_vld_m0", rx_vld0, m_vld);
        chk("frm_err_m0", frm_err0, m_frm);
        chk("ovr_err_m0", ovr_err0, m_ovr);
        if (m_vld) begin
            chk("par_err", par_err, m_par);
            chk("par_err_m0", par_err0, 0);
        end
        if (rx_vld && !prev_vld) rise_cyc = cyc;
        prev_vld = rx_vld;
        frm_cnt += int'(frm_err);
        ovr_cnt += int'(ovr_err);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            uart_rx = 1'b1;
        end
    endtask

    task automatic do_ack();
        @(negedge clk_sys);
        rx_ack = 1'b1;
        @(negedge clk_sys);
        rx_ack = 1'b0;
    endtask

    // ack_off / rst_off: bit-time cycle index at which to assert ack or reset (-1 = never)
    task automatic send_frame(input logic [7:0] d, input logic c, input logic s,
                              input int ack_off, input int rst_off);
        logic [10:0] bits;
        bits = {s, c, d, 1'b0};
        @(negedge clk_sys);
        last_c0 = cyc;
        q.push_back(ev_t'{cyc + LAT, d, c, s});
        for (int k = 0; k < 11 * DIV; k++) begin
            if (k > 0) @(negedge clk_sys);
            if (k == rst_off) begin
                rst_n   = 1'b0;
                uart_rx = 1'b1;
                rx_ack  = 1'b0;
                return;
            end
            uart_rx = bits[k / DIV];
            rx_ack  = (k == ack_off);
        end
    endtask

    logic [7:0] t2_d [3] = '{8'h00, 8'h85, 8'hAA};
    logic       t2_p [3] = '{1'b1, 1'b0, 1'b1};
    int n, f0, o0;

    initial begin
        @(negedge clk_sys);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_vld", rx_vld, 0);
        chk("rst_par", par_err, 0);
        chk("rst_busy", rx_busy, 0);
        idle(2);
        rst_n = 1'b1;
        idle(5);

        send_frame(8'h01, 1'b1, 1'b1, -1, -1);
        chk("t1_data", rx_data, 8'h01);
        chk("t1_vld", rx_vld, 1);
        chk("t1_par", par_err, 0);
        chk("t1_latency", rise_cyc - last_c0, 171);
        do_ack();
        chk("t1_ack", rx_vld, 0);
        idle(20);

        for (int i = 0; i < 3; i++) begin
            send_frame(t2_d[i], 1'b1, 1'b1, -1, -1);
            chk("t2_data", rx_data, t2_d[i]);
            chk("t2_par", par_err, t2_p[i]);
            chk("t2_par_m0", par_err0, 0);
            do_ack();
            idle(20);
        end

        f0 = frm_cnt;
        n  = 0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk_sys);
            uart_rx = (i >= 3);
            n += int'(rx_busy);
        end
        chk("glitch_busy_short", n > 0 && n < 11, 1);
        chk("glitch_vld", rx_vld, 0);
        chk("glitch_frm", frm_cnt - f0, 0);

        f0 = frm_cnt;
        send_frame(8'h55, 1'b0, 1'b0, -1, -1);
        repeat (40) @(negedge clk_sys);
        chk("brk_busy", rx_busy, 1);
        chk("frm_once", frm_cnt - f0, 1);
        chk("frm_data_kept", rx_data, 8'hAA);
        chk("frm_vld", rx_vld, 0);
        idle(20);
        chk("brk_released", rx_busy, 0);
        send_frame(8'h3C, 1'b0, 1'b1, -1, -1);
        chk("after_brk_data", rx_data, 8'h3C);
        chk("after_brk_par", par_err, 0);
        do_ack();
        idle(20);

        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1, -1, -1);
        idle(20);
        send_frame(8'h22, 1'b0, 1'b1, -1, -1);
        chk("ovr_data", rx_data, 8'h22);
        chk("ovr_vld", rx_vld, 1);
        chk("ovr_once", ovr_cnt - o0, 1);
        do_ack();
        idle(20);

        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1, -1, -1);
        idle(20);
        send_frame(8'h22, 1'b0, 1'b1, LAT - 1, -1);
        chk("simack_data", rx_data, 8'h22);
        chk("simack_vld", rx_vld, 1);
        chk("simack_no_ovr", ovr_cnt - o0, 0);
        idle(20);

        f0 = frm_cnt;
        send_frame(8'hF0, 1'b0, 1'b1, -1, 5 * DIV + DIV / 2);
        @(negedge clk_sys);
        chk("midrst_data", rx_data, 8'h00);
        chk("midrst_vld", rx_vld, 0);
        chk("midrst_busy", rx_busy, 0);
        chk("midrst_busy_m0", rx_busy0, 0);
        idle(5);
        rst_n = 1'b1;
        idle(10);
        send_frame(8'h0F, 1'b0, 1'b1, -1, -1);
        chk("postrst_data", rx_data, 8'h0F);
        chk("postrst_vld", rx_vld, 1);
        chk("postrst_par", par_err, 0);
        chk("postrst_frm", frm_cnt - f0, 0);
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
